// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX arbiter and its round-robin picker.
//   BYTE_W      : width of one UART byte.
//   arb_state_e : arbiter FSM states.
//   idx_width() : index width for an N-entry vector (minimum 1 bit).
package uart_tx_arb_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_TX,
      ST_NEXT,
      ST_GAP
   } arb_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches last_id+1, last_id+2, ... modulo N
// and returns the first asserted request as a one-hot grant.
//   req     in  N   request vector
//   last_id in  IW  index served most recently (lowest priority)
//   grant   out N   one-hot winner, zero when nothing requested
//   found   out 1   at least one request was asserted
module uart_rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_id,
   output logic [N-1:0]  grant,
   output logic          found
);

   // Walk the ring starting just after the previous winner.
   always_comb begin
      logic [IW-1:0] idx;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = IW'((32'(last_id) + k) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters with
// packet-granular round-robin grants, a stall timeout and an inter-packet gap.
//   wb_clk_i     in  1          clock
//   wb_rst_i     in  1          synchronous active-high reset
//   req_valid_i  in  NUM_REQ    per-requester byte valid
//   req_data_i   in  8*NUM_REQ  per-requester byte, slice i = [8i+7:8i]
//   req_last_i   in  NUM_REQ    byte closes its packet
//   req_ready_o  out NUM_REQ    byte accepted (combinational, one-hot or zero)
//   tx_wr_o      out 1          one-cycle UART write strobe
//   tx_data_o    out 8          byte to the UART
//   tx_busy_i    in  1          UART busy, rises the cycle after tx_wr_o
//   grant_o      out NUM_REQ    one-hot current owner
//   active_o     out 1          an owner holds the UART
//   timeout_o    out 1          one-cycle pulse on grant revocation
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      tx_wr_o,
   output logic [BYTE_W-1:0]         tx_data_o,
   input  logic                      tx_busy_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      active_o,
   output logic                      timeout_o
);

   localparam int unsigned IW      = idx_width(NUM_REQ);
   localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1) + 1;

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                active_q, active_d;
   logic                tx_wr_q, tx_wr_d;
   logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
   logic                timeout_q, timeout_d;
   logic [IW-1:0]       last_id_q, last_id_d;
   logic                pkt_last_q, pkt_last_d;
   logic                guard_q, guard_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    cnt_inc;

   logic [NUM_REQ-1:0]  pick_grant;
   logic                pick_found;
   logic [IW-1:0]       owner_idx;
   logic [BYTE_W-1:0]   owner_byte;
   logic [BYTE_W-1:0]   pick_byte;
   logic                owner_valid;
   logic                owner_last;

   uart_rr_pick #(
      .N (NUM_REQ)
   ) u_pick (
      .req     (req_valid_i),
      .last_id (last_id_q),
      .grant   (pick_grant),
      .found   (pick_found)
   );

   // Owner / candidate byte selection and owner index encode.
   always_comb begin
      owner_idx  = '0;
      owner_byte = '0;
      pick_byte  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            owner_idx  = IW'(i);
            owner_byte = req_data_i[i*BYTE_W +: BYTE_W];
         end
         if (pick_grant[i]) begin
            pick_byte = req_data_i[i*BYTE_W +: BYTE_W];
         end
      end
   end

   assign owner_valid = |(req_valid_i & grant_q);
   assign owner_last  = |(req_last_i & grant_q);
   assign cnt_inc     = cnt_q + CNT_W'(1);

   // Next-state and next-output logic; stall and gap share one counter.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      active_d   = active_q;
      tx_wr_d    = 1'b0;
      tx_data_d  = tx_data_q;
      timeout_d  = 1'b0;
      last_id_d  = last_id_q;
      pkt_last_d = pkt_last_q;
      guard_d    = 1'b0;
      cnt_d      = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!tx_busy_i && pick_found) begin
               grant_d   = pick_grant;
               active_d  = 1'b1;
               tx_wr_d   = 1'b1;
               tx_data_d = pick_byte;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            pkt_last_d = owner_last;
            guard_d    = 1'b1;
            state_d    = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            // First cycle is a guard: busy has not risen yet.
            if (!guard_q && !tx_busy_i) begin
               if (pkt_last_q) begin
                  last_id_d = owner_idx;
                  grant_d   = '0;
                  active_d  = 1'b0;
                  cnt_d     = '0;
                  state_d   = ST_GAP;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_NEXT;
               end
            end
         end
         ST_NEXT: begin
            if (owner_valid && !tx_busy_i) begin
               tx_wr_d   = 1'b1;
               tx_data_d = owner_byte;
               state_d   = ST_SEND;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               timeout_d = 1'b1;
               last_id_d = owner_idx;
               grant_d   = '0;
               active_d  = 1'b0;
               cnt_d     = '0;
               state_d   = ST_GAP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_GAP: begin
            // GAP_CYCLES=0 still spends one cycle here.
            if (cnt_inc >= CNT_W'(GAP_CYCLES)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         active_q   <= 1'b0;
         tx_wr_q    <= 1'b0;
         tx_data_q  <= '0;
         timeout_q  <= 1'b0;
         last_id_q  <= IW'(NUM_REQ - 1);
         pkt_last_q <= 1'b0;
         guard_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         active_q   <= active_d;
         tx_wr_q    <= tx_wr_d;
         tx_data_q  <= tx_data_d;
         timeout_q  <= timeout_d;
         last_id_q  <= last_id_d;
         pkt_last_q <= pkt_last_d;
         guard_q    <= guard_d;
         cnt_q      <= cnt_d;
      end
   end

   assign req_ready_o = (state_q == ST_SEND) ? grant_q : '0;
   assign tx_wr_o     = tx_wr_q;
   assign tx_data_o   = tx_data_q;
   assign grant_o     = grant_q;
   assign active_o    = active_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet rounds,
// scored against a packet-level round-robin model and a UART busy model.
module tb_uart_tx_arbiter;

   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned GAP_CYCLES = 16;
   localparam int unsigned TIMEOUT    = 1024;

   logic                 wb_clk_i = 1'b0;
   logic                 wb_rst_i;
   logic [NUM_REQ-1:0]   req_valid_i;
   logic [8*NUM_REQ-1:0] req_data_i;
   logic [NUM_REQ-1:0]   req_last_i;
   logic [NUM_REQ-1:0]   req_ready_o;
   logic                 tx_wr_o;
   logic [7:0]           tx_data_o;
   logic                 tx_busy_i;
   logic [NUM_REQ-1:0]   grant_o;
   logic                 active_o;
   logic                 timeout_o;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .GAP_CYCLES (GAP_CYCLES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .req_ready_o (req_ready_o),
      .tx_wr_o     (tx_wr_o),
      .tx_data_o   (tx_data_o),
      .tx_busy_i   (tx_busy_i),
      .grant_o     (grant_o),
      .active_o    (active_o),
      .timeout_o   (timeout_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   // Requester byte buffers: {last, byte}.
   logic [8:0]  rbuf [NUM_REQ][64];
   int          rhead [NUM_REQ];
   int          rtail [NUM_REQ];

   logic [11:0] exp_q[$];      // {id, byte} in expected transmit order
   int          wr_cyc[$];
   int          fall_cyc[$];
   int          to_cyc[$];
   int          mlast;
   int          busy_len;
   int          busy_cnt;
   logic        busy_dyn;
   logic        busy_force;
   logic        prev_active;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      logic [8:0] e;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rhead[i] != rtail[i]) begin
            e = rbuf[i][rhead[i]];
            req_valid_i[i]     = 1'b1;
            req_data_i[i*8+:8] = e[7:0];
            req_last_i[i]      = e[8];
         end else begin
            req_valid_i[i]     = 1'b0;
            req_data_i[i*8+:8] = 8'h00;
            req_last_i[i]      = 1'b0;
         end
      end
      tx_busy_i = busy_dyn | busy_force;
   endtask

   task automatic load(input int id, input logic [7:0] b, input logic last);
      if (rhead[id] == rtail[id]) begin
         rhead[id] = 0;
         rtail[id] = 0;
      end
      rbuf[id][rtail[id]] = {last, b};
      rtail[id]++;
   endtask

   // Packet-level round robin over everything currently queued.
   task automatic plan();
      int h [NUM_REQ];
      int id;
      bit found;
      bit more;
      bit done;
      logic [8:0] e;
      for (int i = 0; i < NUM_REQ; i++) h[i] = rhead[i];
      more = 1'b1;
      while (more) begin
         found = 1'b0;
         id = 0;
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && h[(mlast + k) % NUM_REQ] != rtail[(mlast + k) % NUM_REQ]) begin
               id = (mlast + k) % NUM_REQ;
               found = 1'b1;
            end
         end
         if (!found) begin
            more = 1'b0;
         end else begin
            done = 1'b0;
            while (!done) begin
               e = rbuf[id][h[id]];
               h[id]++;
               exp_q.push_back({4'(id), e[7:0]});
               done = e[8] || (h[id] == rtail[id]);
            end
            mlast = id;
         end
      end
   endtask

   // One clock: sample mid-cycle, then advance and re-drive just after the edge.
   task automatic tick();
      logic [NUM_REQ-1:0] hs;
      logic [11:0] e;
      @(negedge wb_clk_i);
      hs = req_ready_o & req_valid_i;
      if (tx_wr_o === 1'b1) begin
         chk("wr_while_busy", 32'(tx_busy_i), 0);
         chk("wr_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(tx_data_o), 32'(e[7:0]));
            chk("grant_at_wr", 32'(grant_o), 32'(1) << e[11:8]);
            chk("ready_at_wr", 32'(req_ready_o), 32'(1) << e[11:8]);
         end
         wr_cyc.push_back(cyc);
         busy_cnt = busy_len;
      end
      if (timeout_o === 1'b1) begin
         to_cyc.push_back(cyc);
         chk("grant_at_timeout", 32'(grant_o), 0);
      end
      if (prev_active === 1'b1 && active_o === 1'b0) fall_cyc.push_back(cyc);
      prev_active = active_o;
      @(posedge wb_clk_i);
      #1;
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) if (hs[i]) rhead[i]++;
      if (busy_cnt > 0) begin
         busy_dyn = 1'b1;
         busy_cnt--;
      end else begin
         busy_dyn = 1'b0;
      end
      drive();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(exp_q.size()), 0);
      for (int i = 0; i < busy_len + int'(GAP_CYCLES) + 4; i++) tick();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tx_wr"},   32'(tx_wr_o), 0);
      chk({tag, "_tx_data"}, 32'(tx_data_o), 0);
      chk({tag, "_ready"},   32'(req_ready_o), 0);
      chk({tag, "_grant"},   32'(grant_o), 0);
      chk({tag, "_active"},  32'(active_o), 0);
      chk({tag, "_timeout"}, 32'(timeout_o), 0);
   endtask

   task automatic do_reset();
      wb_rst_i = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         rhead[i] = 0;
         rtail[i] = 0;
      end
      busy_cnt   = 0;
      busy_dyn   = 1'b0;
      busy_force = 1'b0;
      drive();
      tick();
      tick();
      check_zero("reset");
      wb_rst_i = 1'b0;
      exp_q.delete();
      wr_cyc.delete();
      fall_cyc.delete();
      to_cyc.delete();
      mlast = NUM_REQ - 1;
   endtask

   initial begin
      int c0;
      int r;
      int n;
      int npk;
      int len;
      wb_rst_i    = 1'b1;
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
      tx_busy_i   = 1'b0;
      busy_len    = 4340;
      prev_active = 1'b0;

      // Single requester, two-byte packet, realistic byte time.
      do_reset();
      load(1, 8'h41, 1'b0);
      load(1, 8'h42, 1'b1);
      plan();
      drive();
      c0 = cyc;
      n = 0;
      while (fall_cyc.size() == 0 && n < 20000) begin
         tick();
         n++;
      end
      chk("t2_fall_seen", 32'(fall_cyc.size()), 1);
      load(3, 8'h33, 1'b1);
      plan();
      drive();
      drain(200);
      chk("t2_first_lat", 32'(wr_cyc[0]), 32'(c0 + 1));
      chk("t2_byte_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'(busy_len + 3));
      chk("t2_active_fall", 32'(fall_cyc[0]), 32'(wr_cyc[1] + busy_len + 2));
      chk("t2_idle_after_gap", 32'(wr_cyc[2]), 32'(fall_cyc[0] + int'(GAP_CYCLES) + 1));

      // Round robin over one-byte packets, two rounds.
      busy_len = 12;
      do_reset();
      load(0, 8'hA0, 1'b1);
      load(2, 8'hA2, 1'b1);
      load(3, 8'hA3, 1'b1);
      plan();
      drive();
      drain(2000);
      load(0, 8'hB0, 1'b1);
      load(3, 8'hB3, 1'b1);
      plan();
      drive();
      drain(2000);

      // Packet lock: req1 waits for the whole req0 packet plus the gap.
      do_reset();
      load(0, 8'h10, 1'b0);
      load(0, 8'h11, 1'b0);
      load(0, 8'h12, 1'b1);
      load(1, 8'h20, 1'b1);
      plan();
      drive();
      drain(2000);
      chk("t4_wr_count", 32'(wr_cyc.size()), 4);
      chk("t4_req1_after_gap", 32'(wr_cyc[3]), 32'(fall_cyc[0] + int'(GAP_CYCLES) + 1));

      // Timeout: req2 stalls mid-packet, req3 pending.
      busy_len = 10;
      do_reset();
      load(2, 8'h55, 1'b0);
      load(3, 8'h66, 1'b1);
      exp_q.push_back({4'd2, 8'h55});
      exp_q.push_back({4'd3, 8'h66});
      drive();
      drain(3000);
      mlast = 3;
      chk("t5_timeout_count", 32'(to_cyc.size()), 1);
      chk("t5_timeout_cyc", 32'(to_cyc[0]), 32'(wr_cyc[0] + busy_len + 2 + int'(TIMEOUT)));
      chk("t5_grant_release", 32'(fall_cyc[0]), 32'(to_cyc[0]));
      chk("t5_req3_after_gap", 32'(wr_cyc[1]), 32'(to_cyc[0] + int'(GAP_CYCLES) + 1));

      // Busy guard at arbitration.
      busy_len = 8;
      do_reset();
      busy_force = 1'b1;
      load(0, 8'h77, 1'b1);
      plan();
      drive();
      for (int i = 0; i < 20; i++) tick();
      chk("t6_no_wr_busy", 32'(wr_cyc.size()), 0);
      busy_force = 1'b0;
      drive();
      r = cyc;
      drain(500);
      chk("t6_wr_after_busy", 32'(wr_cyc[0]), 32'(r + 1));

      // Reset during WAIT_TX of byte 2 of 3.
      busy_len = 40;
      do_reset();
      load(0, 8'hC0, 1'b0);
      load(0, 8'hC1, 1'b0);
      load(0, 8'hC2, 1'b1);
      plan();
      drive();
      n = 0;
      while (wr_cyc.size() < 2 && n < 500) begin
         tick();
         n++;
      end
      chk("t7_two_bytes", 32'(wr_cyc.size()), 2);
      for (int i = 0; i < 5; i++) tick();
      wb_rst_i = 1'b1;
      drive();
      tick();
      check_zero("t7_midreset");
      wb_rst_i = 1'b0;
      load(1, 8'hD1, 1'b1);
      exp_q.delete();
      mlast = NUM_REQ - 1;
      plan();
      drive();
      drain(2000);
      chk("t7_resume_req0", 32'(rhead[0]), 3);

      // Randomized packet rounds, arbitration state carried between rounds.
      do_reset();
      for (int rnd = 0; rnd < 8; rnd++) begin
         busy_len = int'($urandom_range(3, 30));
         for (int id = 0; id < NUM_REQ; id++) begin
            npk = int'($urandom_range(0, 2));
            for (int p = 0; p < npk; p++) begin
               len = int'($urandom_range(1, 4));
               for (int b = 0; b < len; b++) load(id, 8'($urandom), b == len - 1);
            end
         end
         plan();
         drive();
         drain(4000);
      end
      chk("rand_no_timeout", 32'(to_cyc.size()), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
